// File: rtl/psx_mem_arbiter_if.sv
// Client and bridge signal bundle for psx_mem_arbiter.
// slave: arbiter side. master: the environment that drives both clients and the bridge.
interface psx_mem_arbiter_if;
    localparam int unsigned AdrW  = 15;
    localparam int unsigned SubW  = 3;
    localparam int unsigned MaskW = 16;
    localparam int unsigned DataW = 256;
    localparam int unsigned SizeW = 2;

    // Port 0 (GPU) request
    logic             i_req0;
    logic             i_write0;
    logic [SizeW-1:0] i_size0;
    logic [AdrW-1:0]  i_adr0;
    logic [SubW-1:0]  i_sub0;
    logic [MaskW-1:0] i_mask0;
    logic [DataW-1:0] i_data0;

    // Port 1 (DMA/CPU) request
    logic             i_req1;
    logic             i_write1;
    logic [SizeW-1:0] i_size1;
    logic [AdrW-1:0]  i_adr1;
    logic [SubW-1:0]  i_sub1;
    logic [MaskW-1:0] i_mask1;
    logic [DataW-1:0] i_data1;

    // Client responses
    logic             o_ack0;
    logic             o_ack1;
    logic             o_done0;
    logic             o_done1;
    logic             o_rdValid0;
    logic             o_rdValid1;
    logic [DataW-1:0] o_rdData;

    // Bridge command bus
    logic             o_command;
    logic             o_writeElseRead;
    logic [SizeW-1:0] o_commandSize;
    logic [AdrW-1:0]  o_targetAddr;
    logic [SubW-1:0]  o_subAddr;
    logic [MaskW-1:0] o_writeMask;
    logic [DataW-1:0] o_dataOut;

    // Bridge status
    logic             i_memBusy;
    logic             i_memDataValid;
    logic [DataW-1:0] i_memData;

    modport slave (
        input  i_req0, i_write0, i_size0, i_adr0, i_sub0, i_mask0, i_data0,
        input  i_req1, i_write1, i_size1, i_adr1, i_sub1, i_mask1, i_data1,
        output o_ack0, o_ack1, o_done0, o_done1, o_rdValid0, o_rdValid1, o_rdData,
        output o_command, o_writeElseRead, o_commandSize, o_targetAddr,
        output o_subAddr, o_writeMask, o_dataOut,
        input  i_memBusy, i_memDataValid, i_memData
    );

    modport master (
        output i_req0, i_write0, i_size0, i_adr0, i_sub0, i_mask0, i_data0,
        output i_req1, i_write1, i_size1, i_adr1, i_sub1, i_mask1, i_data1,
        input  o_ack0, o_ack1, o_done0, o_done1, o_rdValid0, o_rdValid1, o_rdData,
        input  o_command, o_writeElseRead, o_commandSize, o_targetAddr,
        input  o_subAddr, o_writeMask, o_dataOut,
        output i_memBusy, i_memDataValid, i_memData
    );
endinterface

// File: rtl/psx_mem_arbiter.sv
// Two-client arbiter/sequencer in front of the PSX DDR bridge.
// Port 0 (GPU) has priority over port 1 (DMA/CPU); one transaction in flight at a time.
// Optional feature: define PSX_ARB_STARVE_GUARD_EN to force a port-1 grant after
// STARVE_LIMIT consecutive port-0 grants taken while port 1 was waiting.
module psx_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_nRst,
    psx_mem_arbiter_if.slave  bus
);
    localparam int unsigned CntW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } arbState_t;

    arbState_t state;
    logic      owner;        // 0 = port 0 owns the transaction in flight
    logic      arbitrate;
    logic      grantPort1;
    logic      writeDone;
    logic      readDone;

    // Elaboration-time range check on the starvation limit
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : gBadLimit
        $error("psx_mem_arbiter: STARVE_LIMIT must be 1..7");
    end

`ifdef PSX_ARB_STARVE_GUARD_EN
    logic [CntW-1:0] starveCnt;
    logic            starved;

    // Consecutive port-0 grants taken while port 1 was waiting; saturates at the limit
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            starveCnt <= '0;
        end else if (arbitrate) begin
            if (grantPort1 || !bus.i_req1) begin
                starveCnt <= '0;
            end else if (starveCnt < CntW'(STARVE_LIMIT)) begin
                starveCnt <= starveCnt + CntW'(1);
            end
        end
    end

    // Winner selection: port 0 first unless port 1 has been starved long enough
    always_comb begin
        starved    = 1'b0;
        arbitrate  = 1'b0;
        grantPort1 = 1'b0;
        starved    = (starveCnt >= CntW'(STARVE_LIMIT));
        arbitrate  = (state == IDLE) && (bus.i_req0 || bus.i_req1) && !bus.i_memBusy;
        grantPort1 = bus.i_req1 && (!bus.i_req0 || starved);
    end
`else
    // Winner selection: strict fixed priority, port 0 always wins a tie
    always_comb begin
        arbitrate  = 1'b0;
        grantPort1 = 1'b0;
        arbitrate  = (state == IDLE) && (bus.i_req0 || bus.i_req1) && !bus.i_memBusy;
        grantPort1 = !bus.i_req0;
    end
`endif

    // Completion: writes finish when the bridge drops busy, reads on returned data
    always_comb begin
        writeDone = 1'b0;
        readDone  = 1'b0;
        writeDone = (state == WAIT) &&  bus.o_writeElseRead && !bus.i_memBusy;
        readDone  = (state == WAIT) && !bus.o_writeElseRead &&  bus.i_memDataValid;
    end

    // Responses routed to the owner; read data is a straight passthrough
    assign bus.o_rdValid0 = readDone && !owner;
    assign bus.o_rdValid1 = readDone &&  owner;
    assign bus.o_done0    = (writeDone || readDone) && !owner;
    assign bus.o_done1    = (writeDone || readDone) &&  owner;
    assign bus.o_rdData   = bus.i_memData;

    // Sequencer: latch the winner, pulse ack/command in ISSUE, track to completion
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state               <= IDLE;
            owner               <= 1'b0;
            bus.o_ack0          <= 1'b0;
            bus.o_ack1          <= 1'b0;
            bus.o_command       <= 1'b0;
            bus.o_writeElseRead <= 1'b0;
            bus.o_commandSize   <= '0;
            bus.o_targetAddr    <= '0;
            bus.o_subAddr       <= '0;
            bus.o_writeMask     <= '0;
            bus.o_dataOut       <= '0;
        end else begin
            bus.o_ack0    <= 1'b0;
            bus.o_ack1    <= 1'b0;
            bus.o_command <= 1'b0;
            case (state)
                IDLE: begin
                    if (arbitrate) begin
                        state               <= ISSUE;
                        owner               <= grantPort1;
                        bus.o_ack0          <= !grantPort1;
                        bus.o_ack1          <= grantPort1;
                        bus.o_command       <= 1'b1;
                        bus.o_writeElseRead <= grantPort1 ? bus.i_write1 : bus.i_write0;
                        bus.o_commandSize   <= grantPort1 ? bus.i_size1  : bus.i_size0;
                        bus.o_targetAddr    <= grantPort1 ? bus.i_adr1   : bus.i_adr0;
                        bus.o_subAddr       <= grantPort1 ? bus.i_sub1   : bus.i_sub0;
                        bus.o_writeMask     <= grantPort1 ? bus.i_mask1  : bus.i_mask0;
                        bus.o_dataOut       <= grantPort1 ? bus.i_data1  : bus.i_data0;
                    end
                end
                ISSUE: state <= HOLD;
                // Bridge raises busy one cycle after the command; do not look at it yet
                HOLD:  state <= WAIT;
                WAIT: begin
                    if (writeDone || readDone) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psx_mem_arbiter.sv
// Directed self-checking bench for psx_mem_arbiter.
// Build with PSX_ARB_STARVE_GUARD_EN defined to exercise the starvation guard ordering.
module tb_psx_mem_arbiter;
    logic i_clk = 1'b0;
    logic i_nRst;
    int   checks = 0;
    int   errors = 0;
    int   cmdCount;
    int   nTx;
    logic seen;
    logic expGrant1;

    psx_mem_arbiter_if bus();

    psx_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk  (i_clk),
        .i_nRst (i_nRst),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_ack0"},  256'(bus.o_ack0), 256'd0);
        chk({tag, "_ack1"},  256'(bus.o_ack1), 256'd0);
        chk({tag, "_done0"}, 256'(bus.o_done0), 256'd0);
        chk({tag, "_done1"}, 256'(bus.o_done1), 256'd0);
        chk({tag, "_rdv0"},  256'(bus.o_rdValid0), 256'd0);
        chk({tag, "_rdv1"},  256'(bus.o_rdValid1), 256'd0);
        chk({tag, "_cmd"},   256'(bus.o_command), 256'd0);
        chk({tag, "_wr"},    256'(bus.o_writeElseRead), 256'd0);
        chk({tag, "_size"},  256'(bus.o_commandSize), 256'd0);
        chk({tag, "_adr"},   256'(bus.o_targetAddr), 256'd0);
        chk({tag, "_sub"},   256'(bus.o_subAddr), 256'd0);
        chk({tag, "_mask"},  256'(bus.o_writeMask), 256'd0);
        chk({tag, "_data"},  bus.o_dataOut, 256'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_nRst = 1'b0;
        bus.i_req0 = 1'b0;  bus.i_write0 = 1'b0; bus.i_size0 = 2'd0; bus.i_adr0 = 15'd0;
        bus.i_sub0 = 3'd0;  bus.i_mask0 = 16'd0; bus.i_data0 = 256'd0;
        bus.i_req1 = 1'b0;  bus.i_write1 = 1'b0; bus.i_size1 = 2'd0; bus.i_adr1 = 15'd0;
        bus.i_sub1 = 3'd0;  bus.i_mask1 = 16'd0; bus.i_data1 = 256'd0;
        bus.i_memBusy = 1'b0; bus.i_memDataValid = 1'b0; bus.i_memData = 256'd0;

        // Reset state
        repeat (3) tick();
        chkAllZero("reset");
        chk("reset_rdData", bus.o_rdData, 256'd0);
        i_nRst = 1'b1;
        tick();

        // Test 1: port-0 read, 32 B at 0x0010, data 6 cycles after command
        bus.i_req0 = 1'b1; bus.i_write0 = 1'b0; bus.i_size0 = 2'd1; bus.i_adr0 = 15'h0010;
        tick();
        chk("t1_cmd",  256'(bus.o_command), 256'd1);
        chk("t1_ack0", 256'(bus.o_ack0), 256'd1);
        chk("t1_ack1", 256'(bus.o_ack1), 256'd0);
        chk("t1_size", 256'(bus.o_commandSize), 256'd1);
        chk("t1_adr",  256'(bus.o_targetAddr), 256'h0010);
        chk("t1_wr",   256'(bus.o_writeElseRead), 256'd0);
        bus.i_req0 = 1'b0;
        bus.i_memBusy = 1'b1;
        cmdCount = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.i_memBusy = 1'b0;
            if (bus.o_command) cmdCount++;
            chk("t1_early_rdv0", 256'(bus.o_rdValid0), 256'd0);
            chk("t1_early_ack0", 256'(bus.o_ack0), 256'd0);
        end
        tick();
        bus.i_memDataValid = 1'b1;
        bus.i_memData = 256'hCAFE_F00D_1234_5678;
        #1;
        chk("t1_rdv0",   256'(bus.o_rdValid0), 256'd1);
        chk("t1_done0",  256'(bus.o_done0), 256'd1);
        chk("t1_rdv1",   256'(bus.o_rdValid1), 256'd0);
        chk("t1_done1",  256'(bus.o_done1), 256'd0);
        chk("t1_rdData", bus.o_rdData, 256'hCAFE_F00D_1234_5678);
        chk("t1_onecmd", 256'(cmdCount), 256'd0);
        tick();
        chk("t1_idle_done0", 256'(bus.o_done0), 256'd0);
        chk("t1_idle_rdv0",  256'(bus.o_rdValid0), 256'd0);
        chk("t1_idle_cmd",   256'(bus.o_command), 256'd0);
        bus.i_memDataValid = 1'b0;

        // Test 2: port-1 write, 4 B, sub 3, mask 0x0003, busy for 3 cycles
        bus.i_req1 = 1'b1; bus.i_write1 = 1'b1; bus.i_size1 = 2'd2; bus.i_adr1 = 15'h0123;
        bus.i_sub1 = 3'd3; bus.i_mask1 = 16'h0003; bus.i_data1 = 256'hDEADBEEF;
        tick();
        chk("t2_ack1", 256'(bus.o_ack1), 256'd1);
        chk("t2_ack0", 256'(bus.o_ack0), 256'd0);
        chk("t2_cmd",  256'(bus.o_command), 256'd1);
        chk("t2_wr",   256'(bus.o_writeElseRead), 256'd1);
        chk("t2_size", 256'(bus.o_commandSize), 256'd2);
        chk("t2_adr",  256'(bus.o_targetAddr), 256'h0123);
        chk("t2_sub",  256'(bus.o_subAddr), 256'd3);
        chk("t2_mask", 256'(bus.o_writeMask), 256'h0003);
        chk("t2_data", bus.o_dataOut, 256'hDEADBEEF);
        bus.i_req1 = 1'b0;
        bus.i_memBusy = 1'b1;
        tick();
        chk("t2_hold_done1", 256'(bus.o_done1), 256'd0);
        tick();
        chk("t2_busy_done1", 256'(bus.o_done1), 256'd0);
        tick();
        bus.i_memBusy = 1'b0;
        #1;
        chk("t2_done1", 256'(bus.o_done1), 256'd1);
        chk("t2_done0", 256'(bus.o_done0), 256'd0);
        chk("t2_rdv1",  256'(bus.o_rdValid1), 256'd0);
        chk("t2_rdv0",  256'(bus.o_rdValid0), 256'd0);
        chk("t2_ack0",  256'(bus.o_ack0), 256'd0);
        tick();
        chk("t2_idle_done1", 256'(bus.o_done1), 256'd0);

        // Test 3: simultaneous requests, port 0 first
        bus.i_req0 = 1'b1; bus.i_write0 = 1'b1; bus.i_adr0 = 15'h00AA;
        bus.i_req1 = 1'b1; bus.i_write1 = 1'b1; bus.i_adr1 = 15'h0155;
        tick();
        chk("t3_ack0", 256'(bus.o_ack0), 256'd1);
        chk("t3_ack1", 256'(bus.o_ack1), 256'd0);
        chk("t3_adr0", 256'(bus.o_targetAddr), 256'h00AA);
        bus.i_req0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.o_done0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t3_done0_seen", 256'(seen), 256'd1);
        tick();
        chk("t3_idle_ack1", 256'(bus.o_ack1), 256'd0);
        chk("t3_idle_cmd",  256'(bus.o_command), 256'd0);
        tick();
        chk("t3_ack1", 256'(bus.o_ack1), 256'd1);
        chk("t3_cmd",  256'(bus.o_command), 256'd1);
        chk("t3_adr1", 256'(bus.o_targetAddr), 256'h0155);
        bus.i_req1 = 1'b0;
        tick();
        tick();
        chk("t3_done1", 256'(bus.o_done1), 256'd1);
        tick();

        // Tests 4/5: both ports requesting continuously, writes with bridge idle
        bus.i_req0 = 1'b1; bus.i_write0 = 1'b1; bus.i_adr0 = 15'h0001;
        bus.i_req1 = 1'b1; bus.i_write1 = 1'b1; bus.i_adr1 = 15'h0002;
`ifdef PSX_ARB_STARVE_GUARD_EN
        nTx = 10;
`else
        nTx = 50;
`endif
        for (int t = 0; t < nTx; t++) begin
            seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (bus.o_ack0 || bus.o_ack1) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("t4_grant_seen", 256'(seen), 256'd1);
`ifdef PSX_ARB_STARVE_GUARD_EN
            expGrant1 = ((t % 5) == 4);
`else
            expGrant1 = 1'b0;
`endif
            chk("t4_grant_port1", 256'(bus.o_ack1), 256'(expGrant1));
        end
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        repeat (3) tick();
        chk("t4_idle_cmd", 256'(bus.o_command), 256'd0);

        // Test 6: reset during WAIT of a read, then busy held after reset
        bus.i_req0 = 1'b1; bus.i_write0 = 1'b0; bus.i_size0 = 2'd1; bus.i_adr0 = 15'h0777;
        tick();
        chk("t6_ack0", 256'(bus.o_ack0), 256'd1);
        bus.i_req0 = 1'b0;
        tick();
        tick();
        chk("t6_wait_done0", 256'(bus.o_done0), 256'd0);
        i_nRst = 1'b0;
        bus.i_memBusy = 1'b1;
        bus.i_memDataValid = 1'b1;
        bus.i_memData = 256'h55AA;
        #1;
        chkAllZero("t6_rst");
        tick();
        chk("t6_rst_rdv0", 256'(bus.o_rdValid0), 256'd0);
        bus.i_memDataValid = 1'b0;
        tick();
        i_nRst = 1'b1;
        bus.i_req1 = 1'b1; bus.i_write1 = 1'b1; bus.i_adr1 = 15'h0321;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_busy_cmd",  256'(bus.o_command), 256'd0);
            chk("t6_busy_ack1", 256'(bus.o_ack1), 256'd0);
        end
        bus.i_memBusy = 1'b0;
        tick();
        chk("t6_cmd",  256'(bus.o_command), 256'd1);
        chk("t6_ack1", 256'(bus.o_ack1), 256'd1);
        chk("t6_adr",  256'(bus.o_targetAddr), 256'h0321);
        bus.i_req1 = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
